// File: rtl/audio_meter_pkg.sv
// Shared types and elaboration-time threshold helpers for the audio level meter.
// Thresholds are returned 64 bits wide so any sample width compares cleanly.
package audio_meter_pkg;

   localparam int W_DEFAULT = 16;
   localparam int MAX_LEDS  = 64;

   typedef logic [W_DEFAULT-2:0] mag_t;
   typedef logic [63:0] thr_arr_t [MAX_LEDS];

   // Evenly spaced steps over the magnitude range; LED i lights at (i+1)/(n+1) of full scale.
   function automatic logic [63:0] lin_thr(input int i, input int w, input int n);
      logic [63:0] full;
      full = 64'd1 << (w - 1);
      return (64'(i + 1) * full) / 64'(n + 1);
   endfunction

   // 6 dB per LED, top LED at half scale; never below 1 so a silent channel stays dark.
   function automatic logic [63:0] log_thr(input int i, input int w, input int n);
      logic [63:0] v;
      v = (64'd1 << (w - 1)) >> (n - i);
      return (v == 64'd0) ? 64'd1 : v;
   endfunction

endpackage

// File: rtl/audio_level_meter_envelope.sv
// level_envelope: one channel's peak-hold/decay envelope, updated once per sample of that channel.
// Latency 1 cycle from en to env; no backpressure, accepts an update every cycle.
module level_envelope #(
   parameter int W            = 16,
   parameter int HOLD_SAMPLES = 2400,
   parameter int DECAY_SHIFT  = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-2:0] mag,
   output logic [W-2:0] env
);

   localparam int HW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;

   logic [HW-1:0] hold;
   logic [W-2:0]  step;
   logic [W-2:0]  decayed;

   // Minimum step of 1 lets the envelope always reach zero; step <= env so no underflow.
   always_comb begin
      step = env >> DECAY_SHIFT;
      if (step == '0) step = (W-1)'(1);
      decayed = env - step;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         env  <= '0;
         hold <= '0;
      end else if (en) begin
         if (mag >= env) begin
            env  <= mag;
            hold <= HW'(HOLD_SAMPLES);
         end else if (hold != '0) begin
            hold <= hold - HW'(1);
         end else begin
            env <= (mag > decayed) ? mag : decayed;
         end
      end
   end

endmodule

// File: rtl/audio_level_meter.sv
// Multi-channel PCM level meter: per-channel peak envelopes, bar graph of the loudest, clip timer.
// Latency 3 cycles sample_valid -> ledr/peak_mag; no backpressure. AUDIO_METER_LOG_SCALE_EN selects 6 dB/LED thresholds.
module audio_level_meter
   import audio_meter_pkg::*;
#(
   parameter int W            = 16,
   parameter int NUM_CH       = 2,
   parameter int NUM_LEDS     = 18,
   parameter int HOLD_SAMPLES = 2400,
   parameter int DECAY_SHIFT  = 3,
   parameter int CLIP_HOLD    = 25000000,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [W-1:0]        sample_data,
   input  logic [CH_W-1:0]     sample_ch,
   output logic [NUM_LEDS-1:0] ledr,
   output logic [W-2:0]        peak_mag,
   output logic                clip
);

   localparam int           TW       = (CLIP_HOLD > 1) ? $clog2(CLIP_HOLD) : 1;
   localparam logic [W-2:0] MAG_MAX  = '1;
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   logic [W-2:0]        mag_in;
   logic                s1_vld;
   logic [W-2:0]        s1_mag;
   logic [CH_W-1:0]     s1_ch;
   logic [W-2:0]        env [NUM_CH];
   logic [W-2:0]        max_env;
   logic [NUM_LEDS-1:0] lit;
   logic [TW-1:0]       clip_timer;
   logic                clip_load;

   // Two's-complement negate on the low bits; the most negative code saturates.
   always_comb begin
      if (!sample_data[W-1])
         mag_in = sample_data[W-2:0];
      else if (sample_data == MOST_NEG)
         mag_in = MAG_MAX;
      else
         mag_in = (~sample_data[W-2:0]) + (W-1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s1_mag <= '0;
         s1_ch  <= '0;
      end else begin
         s1_vld <= sample_valid && ({1'b0, sample_ch} < (CH_W+1)'(NUM_CH));
         s1_mag <= mag_in;
         s1_ch  <= sample_ch;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      level_envelope #(
         .W            (W),
         .HOLD_SAMPLES (HOLD_SAMPLES),
         .DECAY_SHIFT  (DECAY_SHIFT)
      ) u_env (
         .clk   (clk),
         .reset (reset),
         .en    (s1_vld && (s1_ch == CH_W'(c))),
         .mag   (s1_mag),
         .env   (env[c])
      );
   end

   always_comb begin
      max_env = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (env[c] > max_env) max_env = env[c];
   end

   // Thresholds are non-decreasing in i, so the compare vector is always a thermometer code.
   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
`ifdef AUDIO_METER_LOG_SCALE_EN
      localparam logic [63:0] THR = log_thr(i, W, NUM_LEDS);
`else
      localparam logic [63:0] THR = lin_thr(i, W, NUM_LEDS);
`endif
      assign lit[i] = ({{(64-(W-1)){1'b0}}, max_env} >= THR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         peak_mag <= '0;
         ledr     <= '0;
      end else begin
         peak_mag <= max_env;
         ledr     <= lit;
      end
   end

   // Load term keeps clip high in the load cycle and makes retriggers seamless.
   assign clip_load = s1_vld && (s1_mag == MAG_MAX);
   assign clip      = (clip_timer != '0) || clip_load;

   always_ff @(posedge clk) begin
      if (reset)
         clip_timer <= '0;
      else if (clip_load)
         clip_timer <= TW'(CLIP_HOLD - 1);
      else if (clip_timer != '0)
         clip_timer <= clip_timer - TW'(1);
   end

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter: table vectors, corner sequences and random traffic vs. a reference model.
module tb_audio_level_meter;
   import audio_meter_pkg::*;

   localparam int W        = 16;
   localparam int NUM_CH   = 3;
   localparam int CH_W     = 2;
   localparam int NUM_LEDS = 18;
   localparam int HOLD     = 4;
   localparam int DSH      = 3;
   localparam int CLIPH    = 8;
   localparam int MAXM     = (1 << (W - 1)) - 1;

`ifdef AUDIO_METER_LOG_SCALE_EN
   `define SEL(lin_v, log_v) log_v
`else
   `define SEL(lin_v, log_v) lin_v
`endif

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                sample_valid = 1'b0;
   logic [W-1:0]        sample_data = '0;
   logic [CH_W-1:0]     sample_ch = '0;
   logic [NUM_LEDS-1:0] ledr;
   logic [W-2:0]        peak_mag;
   logic                clip;

   audio_level_meter #(
      .W(W), .NUM_CH(NUM_CH), .NUM_LEDS(NUM_LEDS),
      .HOLD_SAMPLES(HOLD), .DECAY_SHIFT(DSH), .CLIP_HOLD(CLIPH)
   ) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
      .sample_ch(sample_ch), .ledr(ledr), .peak_mag(peak_mag), .clip(clip)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: envelopes per channel, the sample accepted last edge, last full-scale edge.
   int env_m  [NUM_CH];
   int hold_m [NUM_CH];
   bit pend_v;
   int pend_mag;
   int pend_ch;
   int now = 0;
   int last_fs = -1000000;
   int exp_peak = 0;
   bit exp_clip = 1'b0;

   function automatic longint thr(input int i);
`ifdef AUDIO_METER_LOG_SCALE_EN
      longint v;
      v = longint'(1 << (W - 1)) / (longint'(1) << (NUM_LEDS - i));
      return (v < 1) ? 1 : v;
`else
      return (longint'(i + 1) * longint'(1 << (W - 1))) / longint'(NUM_LEDS + 1);
`endif
   endfunction

   function automatic logic [NUM_LEDS-1:0] ledr_of(input int p);
      logic [NUM_LEDS-1:0] r;
      for (int i = 0; i < NUM_LEDS; i++) r[i] = (longint'(p) >= thr(i));
      return r;
   endfunction

   function automatic int mag_of(input logic [W-1:0] d);
      int s;
      s = int'($signed(d));
      if (s == -(1 << (W - 1))) return MAXM;
      return (s < 0) ? -s : s;
   endfunction

   function automatic int max_env_m();
      int m;
      m = 0;
      for (int c = 0; c < NUM_CH; c++) if (env_m[c] > m) m = env_m[c];
      return m;
   endfunction

   task automatic model_apply(input int c, input int m);
      int st;
      int nv;
      if (m >= env_m[c]) begin
         env_m[c]  = m;
         hold_m[c] = HOLD;
      end else if (hold_m[c] != 0) begin
         hold_m[c]--;
      end else begin
         st = env_m[c] / (1 << DSH);
         if (st < 1) st = 1;
         nv = env_m[c] - st;
         env_m[c] = (m > nv) ? m : nv;
      end
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, now);
      end
   endtask

   // One clock: drive inputs, clock, advance the model, compare every output.
   task automatic step(input bit v, input int d, input int ch, input bit r);
      reset        = r;
      sample_valid = v;
      sample_data  = d[W-1:0];
      sample_ch    = ch[CH_W-1:0];
      @(posedge clk);
      #1;
      now++;
      if (r) begin
         for (int c = 0; c < NUM_CH; c++) begin
            env_m[c]  = 0;
            hold_m[c] = 0;
         end
         pend_v   = 1'b0;
         last_fs  = -1000000;
         exp_peak = 0;
      end else begin
         exp_peak = max_env_m();
         if (pend_v) model_apply(pend_ch, pend_mag);
         pend_v = v && (ch < NUM_CH);
         if (pend_v) begin
            pend_mag = mag_of(d[W-1:0]);
            pend_ch  = ch;
            if (pend_mag == MAXM) last_fs = now;
         end
      end
      exp_clip = ((now - last_fs) < CLIPH);
      check("peak_mag", longint'(peak_mag), longint'(exp_peak));
      check("ledr", longint'(ledr), longint'(ledr_of(exp_peak)));
      check("clip", longint'(clip), longint'(exp_clip));
      reset        = 1'b0;
      sample_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0);
   endtask

   typedef struct {
      bit                  rst;
      int                  data;
      int                  ch;
      int                  exp_peak;
      logic [NUM_LEDS-1:0] exp_ledr;
   } vec_t;

   vec_t vecs [10];
   int   clip_cnt;
   int   sel;
   int   rd;

   initial begin
      vecs[0] = '{1'b1, 'h8000, 0, 32767, `SEL(18'h3FFFF, 18'h3FFFF)};
      vecs[1] = '{1'b1, 'hFFFF, 0, 1,     `SEL(18'h00000, 18'h0000F)};
      vecs[2] = '{1'b0, 3449,   0, 3449,  `SEL(18'h00003, 18'h07FFF)};
      vecs[3] = '{1'b1, 3448,   0, 3448,  `SEL(18'h00001, 18'h07FFF)};
      vecs[4] = '{1'b1, 1724,   0, 1724,  `SEL(18'h00001, 18'h03FFF)};
      vecs[5] = '{1'b1, 1723,   0, 1723,  `SEL(18'h00000, 18'h03FFF)};
      vecs[6] = '{1'b1, 16384,  1, 16384, `SEL(18'h001FF, 18'h3FFFF)};
      vecs[7] = '{1'b1, 10000,  1, 10000, `SEL(18'h0001F, 18'h1FFFF)};
      vecs[8] = '{1'b0, 0,      0, 10000, `SEL(18'h0001F, 18'h1FFFF)};
      vecs[9] = '{1'b0, 'h8001, 2, 32767, `SEL(18'h3FFFF, 18'h3FFFF)};

      // Reset state
      step(1'b0, 0, 0, 1'b1);
      check("reset_peak", longint'(peak_mag), 0);
      check("reset_ledr", longint'(ledr), 0);
      check("reset_clip", longint'(clip), 0);

      foreach (vecs[n]) begin
         if (vecs[n].rst) step(1'b0, 0, 0, 1'b1);
         step(1'b1, vecs[n].data, vecs[n].ch, 1'b0);
         idle(2);
         check($sformatf("vec%0d_peak", n), longint'(peak_mag), longint'(vecs[n].exp_peak));
         check($sformatf("vec%0d_ledr", n), longint'(ledr), longint'(vecs[n].exp_ledr));
      end

      // Hold for HOLD samples, then one decay step
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 32767, 0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, 0, 0, 1'b0);
      idle(2);
      check("hold_peak", longint'(peak_mag), 32767);
      step(1'b1, 0, 0, 1'b0);
      idle(2);
      check("decay_peak", longint'(peak_mag), 28672);

      // Channel independence and out-of-range channel
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 10000, 1, 1'b0);
      for (int k = 0; k < 10; k++) step(1'b1, 0, 0, 1'b0);
      idle(2);
      check("indep_peak", longint'(peak_mag), 10000);
      step(1'b1, 30000, 3, 1'b0);
      idle(2);
      check("badch_peak", longint'(peak_mag), 10000);

      // Reset flushes an in-flight full-scale sample
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 'h8000, 0, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      check("flush_peak", longint'(peak_mag), 0);
      check("flush_ledr", longint'(ledr), 0);
      check("flush_clip", longint'(clip), 0);
      idle(3);
      check("flush_late_peak", longint'(peak_mag), 0);
      check("flush_late_clip", longint'(clip), 0);

      // Clip lasts exactly CLIP_HOLD cycles
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 'h8000, 0, 1'b0);
      clip_cnt = int'(clip);
      for (int k = 0; k < CLIPH + 4; k++) begin
         idle(1);
         clip_cnt += int'(clip);
      end
      check("clip_len", clip_cnt, CLIPH);

      // Retrigger after 6 cycles extends with no gap: 6 + CLIP_HOLD cycles high
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 'h8000, 0, 1'b0);
      clip_cnt = int'(clip);
      idle(5);
      clip_cnt += 5;
      step(1'b1, 'h7FFF, 1, 1'b0);
      clip_cnt = int'(clip) ? clip_cnt + 1 : clip_cnt;
      for (int k = 0; k < CLIPH + 4; k++) begin
         idle(1);
         clip_cnt += int'(clip);
      end
      check("clip_retrig_len", clip_cnt, 6 + CLIPH);

      // Random traffic against the model
      step(1'b0, 0, 0, 1'b1);
      for (int k = 0; k < 3000; k++) begin
         sel = int'($urandom_range(0, 4));
         case (sel)
            0:       rd = 'h8000;
            1:       rd = 'h7FFF;
            2:       rd = int'($urandom_range(0, 40)) - 20;
            3:       rd = int'($urandom_range(0, 4000));
            default: rd = int'($urandom);
         endcase
         step($urandom_range(0, 3) != 0, rd, int'($urandom_range(0, 3)),
              $urandom_range(0, 299) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
